pcie_egress_arbiter: RTL and testbench

- Egress stage directly downstream of device3.
- Merges its two per-class FIFO streams (fifo4x8 #0 and #1) onto one MAIN_SIZE-bit link.
- Round-robin with a bounded burst per grant, downstream back-pressure, and masking of a port while its Error flag is set.
- Pops device3's FIFOs through a show-ahead interface, so data is valid whenever the FIFO is not empty.

---
 rtl/egress_pkg.sv | 14 +
 rtl/rr_burst_fsm.sv | 95 +++++++++
 rtl/pcie_egress_arbiter.sv | 68 ++++++
 tb/tb_pcie_egress_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// Shared types and constants for the PCIe egress arbiter.
// State encoding of the round-robin burst FSM and its burst counter width.
package egress_pkg;

    // Burst counter width; covers BURST_LEN up to 15.
    localparam int unsigned BurstW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_burst_fsm.sv
// Two-port round-robin grant FSM with a bounded burst per grant.
// Owns grant state, burst count, last-served port and the combinational pops.
module rr_burst_fsm
    import egress_pkg::*;
#(
    parameter int unsigned BurstLen = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic elig0_i,
    input  logic elig1_i,
    output logic pop0_o,
    output logic pop1_o
);

    localparam logic [BurstW-1:0] BurstMax = BurstW'(BurstLen);

    arb_state_e        state_q, state_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              last_q, last_d;
    logic [BurstW-1:0] burst_inc;
    logic              burst_done;

    assign burst_inc  = burst_q + BurstW'(1);
    // Count saturates so a long single-port stream still yields as soon as the
    // other port becomes eligible.
    assign burst_done = (burst_inc >= BurstMax);

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        pop0_o  = 1'b0;
        pop1_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (elig0_i && elig1_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (elig0_i) begin
                    state_d = StGnt0;
                end else if (elig1_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (elig0_i) begin
                    pop0_o = 1'b1;
                    last_d = 1'b0;
                    if (burst_done && elig1_i) begin
                        state_d = StGnt1;
                        burst_d = '0;
                    end else if (!burst_done) begin
                        burst_d = burst_inc;
                    end
                end else begin
                    burst_d = '0;
                    state_d = elig1_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (elig1_i) begin
                    pop1_o = 1'b1;
                    last_d = 1'b1;
                    if (burst_done && elig0_i) begin
                        state_d = StGnt0;
                        burst_d = '0;
                    end else if (!burst_done) begin
                        burst_d = burst_inc;
                    end
                end else begin
                    burst_d = '0;
                    state_d = elig0_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (reset_i) begin
            pop0_o = 1'b0;
            pop1_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            burst_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Merges the two show-ahead class FIFOs of device3 onto one link, with
// round-robin bursts, back-pressure, error masking and per-port word counters.
module pcie_egress_arbiter
    import egress_pkg::*;
#(
    parameter int unsigned MAIN_SIZE = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAIN_SIZE-1:0] in0,
    input  logic [MAIN_SIZE-1:0] in1,
    input  logic                 empty0,
    input  logic                 empty1,
    input  logic                 Error0,
    input  logic                 Error1,
    input  logic                 almost_full_down,
    output logic                 pop0,
    output logic                 pop1,
    output logic [MAIN_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 src_out,
    output logic [1:0]           err_seen,
    output logic [COUNT_W-1:0]   cnt0,
    output logic [COUNT_W-1:0]   cnt1
);

    logic elig0, elig1;

    assign elig0 = !empty0 && !Error0 && !almost_full_down;
    assign elig1 = !empty1 && !Error1 && !almost_full_down;

    rr_burst_fsm #(
        .BurstLen(BURST_LEN)
    ) u_fsm (
        .clk_i  (clk),
        .reset_i(reset),
        .elig0_i(elig0),
        .elig1_i(elig1),
        .pop0_o (pop0),
        .pop1_o (pop1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            src_out   <= 1'b0;
            err_seen  <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            valid_out <= pop0 | pop1;
            if (pop0) begin
                data_out <= in0;
                src_out  <= 1'b0;
                cnt0     <= cnt0 + COUNT_W'(1);
            end else if (pop1) begin
                data_out <= in1;
                src_out  <= 1'b1;
                cnt1     <= cnt1 + COUNT_W'(1);
            end
            err_seen <= err_seen | {Error1, Error0};
        end
    end

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Directed, scoreboard-checked bench for pcie_egress_arbiter (4-bit counters).
module tb_pcie_egress_arbiter;

    localparam int unsigned MW = 8;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          src;
        logic [MW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, empty0, empty1, Error0, Error1, almost_full_down;
    logic [MW-1:0] in0, in1;
    logic          pop0, pop1, valid_out, src_out;
    logic [MW-1:0] data_out;
    logic [1:0]    err_seen;
    logic [CW-1:0] cnt0, cnt1;

    pcie_egress_arbiter #(
        .MAIN_SIZE(MW),
        .BURST_LEN(4),
        .COUNT_W  (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in0             (in0),
        .in1             (in1),
        .empty0          (empty0),
        .empty1          (empty1),
        .Error0          (Error0),
        .Error1          (Error1),
        .almost_full_down(almost_full_down),
        .pop0            (pop0),
        .pop1            (pop1),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .src_out         (src_out),
        .err_seen        (err_seen),
        .cnt0            (cnt0),
        .cnt1            (cnt1)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            avail0, avail1;
    logic [MW-1:0] head0, head1;
    exp_t          exp_q[$];
    logic          src_log[$];
    logic [MW-1:0] data_log[$];
    logic [CW-1:0] cnt0_at[$];
    logic [CW-1:0] cnt1_at[$];
    int            out_cyc[$];
    logic [MW-1:0] data_m;
    logic          src_m;
    logic [CW-1:0] cnt0_m, cnt1_m;
    logic [1:0]    err_m;
    logic          last_p0, last_p1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in0    = head0;
        in1    = head1;
        empty0 = (avail0 == 0);
        empty1 = (avail1 == 0);
    endtask

    // One clock: sample pops mid-cycle, push expectations, compare after the edge.
    task automatic step();
        logic p0, p1, rst_e;
        exp_t e;
        @(negedge clk);
        p0 = pop0;
        p1 = pop1;
        rst_e = reset;
        if (rst_e) check("pop_in_reset", {30'd0, p1, p0}, 32'd0);
        check("pop_exclusive", {31'd0, p0 & p1}, 32'd0);
        if (!rst_e) begin
            err_m = err_m | {Error1, Error0};
            if (p0) exp_q.push_back('{src: 1'b0, data: head0});
            else if (p1) exp_q.push_back('{src: 1'b1, data: head1});
        end
        @(posedge clk);
        #1;
        cyc++;
        last_p0 = p0;
        last_p1 = p1;
        if (rst_e) begin
            exp_q.delete();
            src_log.delete();
            data_log.delete();
            cnt0_at.delete();
            cnt1_at.delete();
            out_cyc.delete();
            data_m = '0;
            src_m  = 1'b0;
            cnt0_m = '0;
            cnt1_m = '0;
            err_m  = '0;
        end else if (p0 || p1) begin
            e = exp_q.pop_front();
            data_m = e.data;
            src_m  = e.src;
            if (p0) begin
                head0++;
                avail0--;
                cnt0_m++;
            end else begin
                head1++;
                avail1--;
                cnt1_m++;
            end
        end
        check("valid_out", {31'd0, valid_out}, {31'd0, !rst_e && (p0 || p1)});
        check("data_out", {24'd0, data_out}, {24'd0, data_m});
        check("src_out", {31'd0, src_out}, {31'd0, src_m});
        check("cnt0", {28'd0, cnt0}, {28'd0, cnt0_m});
        check("cnt1", {28'd0, cnt1}, {28'd0, cnt1_m});
        check("err_seen", {30'd0, err_seen}, {30'd0, err_m});
        if (!rst_e && (p0 || p1)) begin
            src_log.push_back(src_out);
            data_log.push_back(data_out);
            cnt0_at.push_back(cnt0);
            cnt1_at.push_back(cnt1);
            out_cyc.push_back(cyc);
        end
        drive();
    endtask

    task automatic do_reset(input int a0, input int a1);
        reset            = 1'b1;
        Error0           = 1'b0;
        Error1           = 1'b0;
        almost_full_down = 1'b0;
        head0            = 8'hA0;
        head1            = 8'hB0;
        avail0           = a0;
        avail1           = a1;
        drive();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (src_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, {31'd0, src_log.size() >= n}, 32'd1);
    endtask

    initial begin
        int n0, n1, nlow;
        logic [MW-1:0] first_w;
        logic seen0;
        logic [11:0] fair_pat;

        // Reset held 3 cycles with both FIFOs full.
        reset = 1'b1; Error0 = 1'b0; Error1 = 1'b0; almost_full_down = 1'b0;
        head0 = 8'hA0; head1 = 8'hB0; avail0 = 1000; avail1 = 1000;
        drive();
        repeat (3) step();
        reset = 1'b0;

        // Fairness: 4xA, 4xB, 4xA back to back.
        wait_words("fair_timeout", 12, 40);
        fair_pat = 12'b0000_1111_0000;
        for (int i = 0; i < 12; i++) begin
            check("fair_src", {31'd0, src_log[i]}, {31'd0, fair_pat[11-i]});
        end
        first_w = data_log[0];
        check("fair_first_word", {24'd0, first_w}, 32'h0000_00A0);
        check("fair_first_b", {24'd0, data_log[4]}, 32'h0000_00B0);
        check("fair_continuous", out_cyc[11] - out_cyc[0], 32'd11);
        check("fair_cnt0_at8", {28'd0, cnt0_at[7]}, 32'd4);
        check("fair_cnt1_at8", {28'd0, cnt1_at[7]}, 32'd4);

        // Single port streams with no forced switch.
        do_reset(10, 0);
        repeat (14) step();
        check("single_words", src_log.size(), 32'd10);
        n1 = 0;
        foreach (src_log[i]) n1 += int'(src_log[i]);
        check("single_src1_count", n1, 32'd0);
        check("single_continuous", out_cyc[9] - out_cyc[0], 32'd9);
        check("single_cnt0", {28'd0, cnt0}, 32'd10);

        // Back-pressure mid-burst.
        do_reset(1000, 1000);
        wait_words("bp_pre_timeout", 2, 10);
        almost_full_down = 1'b1;
        n0 = 0;
        nlow = 0;
        repeat (5) begin
            step();
            n0 += int'(last_p0 | last_p1);
            nlow += int'(!valid_out);
        end
        check("bp_no_pops", n0, 32'd0);
        check("bp_valid_low", nlow, 32'd5);
        almost_full_down = 1'b0;
        wait_words("bp_post_timeout", 8, 20);
        check("bp_resume_src", {31'd0, src_log[2]}, 32'd1);

        // Error masking of port 0.
        do_reset(1000, 1000);
        Error0 = 1'b1;
        n0 = 0;
        n1 = 0;
        repeat (6) begin
            step();
            n0 += int'(last_p0);
            n1 += int'(last_p1);
        end
        check("err_pop0_masked", n0, 32'd0);
        check("err_pop1_count", n1, 32'd5);
        check("err_seen_set", {30'd0, err_seen}, 32'd1);
        Error0 = 1'b0;
        seen0 = 1'b0;
        for (int k = 0; k < 10 && !seen0; k++) begin
            step();
            seen0 = last_p0;
        end
        check("err_port0_resumes", {31'd0, seen0}, 32'd1);
        check("err_seen_sticky", {30'd0, err_seen}, 32'd1);

        // Counter wrap at 4 bits.
        do_reset(17, 0);
        wait_words("wrap_timeout", 17, 30);
        check("wrap_cnt_15", {28'd0, cnt0_at[14]}, 32'd15);
        check("wrap_cnt_0", {28'd0, cnt0_at[15]}, 32'd0);
        check("wrap_cnt_1", {28'd0, cnt0_at[16]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
